// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the SRAM slave state type.
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SIZE_BYTE  = 3'd0,
    SIZE_HALF  = 3'd1,
    SIZE_WORD  = 3'd2,
    SIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } slv_state_e;

  // NONSEQ and SEQ both carry a real transfer; IDLE and BUSY do not.
  function automatic logic trans_active(input logic [1:0] trans);
    return trans[1];
  endfunction

endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane strobe and alignment check for one AHB access.
module ahb_byte_strobe #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [$clog2(DATA_WIDTH/8)-1:0] i_addr_lo,
  input  logic [2:0]                      i_size,
  output logic [DATA_WIDTH/8-1:0]         o_strb,
  output logic                            o_misalign
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);

  // Lanes addr_lo .. addr_lo + 2^size - 1; oversize accesses are clipped to the bus.
  always_comb begin
    int lo;
    int span;
    o_strb     = '0;
    o_misalign = 1'b0;
    lo         = int'(i_addr_lo);
    if (i_size > 3'(LB)) begin
      span = NB;
    end else begin
      span = 32'sd1 << i_size;
    end
    o_misalign = (lo % span) != 32'sd0;
    for (int k = 0; k < NB; k++) begin
      o_strb[k] = (k >= lo) && (k < lo + span);
    end
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port SRAM slave with wait states, byte-lane writes and ERROR responses.
// Optional macro AHB_SRAM_PROT_EN: unprivileged access at or above PROT_BASE is an error.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 1,
  parameter int PROT_BASE   = 768
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic                  HWRITE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADY,
  output logic                  HRESP
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int LB    = $clog2(NB);
  localparam int MAW   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int WCW   = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
  localparam int WLOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;

  slv_state_e            r_state, w_state_nxt;
  logic                  r_hready;
  hresp_e                r_hresp;
  logic [DATA_WIDTH-1:0] r_hrdata, w_hrdata_nxt, w_rd_raw;
  logic [MAW-1:0]        r_word_q, w_rd_word;
  logic                  r_write_q, w_rd_write;
  logic [NB-1:0]         r_strb_q, w_strb;
  logic [WCW-1:0]        r_wait_cnt, w_wait_cnt_nxt;
  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_accept, w_misalign, w_range_err, w_size_err;
  logic                  w_prot_hit, w_prot_err, w_err, w_commit, w_fwd;
  logic                  w_unused;
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  ahb_byte_strobe #(.DATA_WIDTH(DATA_WIDTH)) u_strobe (
    .i_addr_lo  (HADDR[LB-1:0]),
    .i_size     (HSIZE),
    .o_strb     (w_strb),
    .o_misalign (w_misalign)
  );

  assign w_word      = HADDR >> LB;
  assign w_accept    = r_hready & HSEL & trans_active(HTRANS);
  assign w_range_err = w_word >= ADDR_WIDTH'(MEM_DEPTH);
  assign w_size_err  = HSIZE > 3'(LB);
  assign w_prot_hit  = w_word >= ADDR_WIDTH'(PROT_BASE);
`ifdef AHB_SRAM_PROT_EN
  assign w_prot_err  = w_prot_hit & ~HPROT[1];
`else
  assign w_prot_err  = 1'b0;
`endif
  assign w_err       = w_range_err | w_size_err | w_misalign | w_prot_err;
  assign w_unused    = ^{HBURST, HPROT, HTRANS[0], w_prot_hit};

  // The write in its DATA cycle commits on the same edge that may load a following read.
  assign w_commit   = (r_state == ST_DATA) & r_write_q;
  assign w_rd_word  = w_accept ? w_word[MAW-1:0] : r_word_q;
  assign w_rd_write = w_accept ? HWRITE : r_write_q;
  assign w_fwd      = w_commit & (r_word_q == w_rd_word);
  assign w_rd_raw   = r_mem[w_rd_word];

  // Next-state and wait-counter decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            w_state_nxt    = ST_WAIT;
            w_wait_cnt_nxt = WCW'(WLOAD);
          end else begin
            w_state_nxt = ST_DATA;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_nxt = ST_DATA;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt - WCW'(1);
        end
      end
      ST_ERR1: w_state_nxt = ST_ERR2;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Read data for the upcoming DATA cycle, merging a same-edge write.
  always_comb begin
    w_hrdata_nxt = '0;
    if ((w_state_nxt == ST_DATA) && !w_rd_write) begin
      for (int k = 0; k < NB; k++) begin
        w_hrdata_nxt[8*k +: 8] = (w_fwd && r_strb_q[k]) ? HWDATA[8*k +: 8] : w_rd_raw[8*k +: 8];
      end
    end else begin
      w_hrdata_nxt = '0;
    end
  end

  // State, registered bus outputs and captured address phase.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state    <= ST_IDLE;
      r_hready   <= 1'b1;
      r_hresp    <= RESP_OKAY;
      r_hrdata   <= '0;
      r_wait_cnt <= '0;
      r_word_q   <= '0;
      r_write_q  <= 1'b0;
      r_strb_q   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hready   <= (w_state_nxt != ST_WAIT) && (w_state_nxt != ST_ERR1);
      r_hresp    <= ((w_state_nxt == ST_ERR1) || (w_state_nxt == ST_ERR2)) ? RESP_ERROR : RESP_OKAY;
      r_hrdata   <= w_hrdata_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_accept) begin
        r_word_q  <= w_word[MAW-1:0];
        r_write_q <= HWRITE;
        r_strb_q  <= w_strb;
      end
    end
  end

  // Storage array; contents survive reset.
  always_ff @(posedge HCLK) begin
    if (w_commit) begin
      for (int k = 0; k < NB; k++) begin
        if (r_strb_q[k]) begin
          r_mem[r_word_q][8*k +: 8] <= HWDATA[8*k +: 8];
        end
      end
    end
  end

  assign HRDATA = r_hrdata;
  assign HREADY = r_hready;
  assign HRESP  = r_hresp;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomized bench for ahb_sram_slave: one instance with one wait state, one with none.
module tb_ahb_sram_slave;

`ifdef AHB_SRAM_PROT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        hreset;
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic        hwrite [2];
  logic [31:0] hwdata [2];
  logic [1:0]  htrans [2];
  logic [2:0]  hsize  [2];
  logic [3:0]  hprot  [2];
  logic [2:0]  hburst [2];
  logic [31:0] hrdata [2];
  logic        hready [2];
  logic        hresp  [2];

  logic [31:0] mdl  [2][1024];
  bit          mval [2][1024];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ahb_sram_slave #(.WAIT_STATES(1)) u_dut0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[0]), .HADDR(haddr[0]), .HWRITE(hwrite[0]),
    .HWDATA(hwdata[0]), .HTRANS(htrans[0]), .HSIZE(hsize[0]), .HPROT(hprot[0]),
    .HBURST(hburst[0]), .HRDATA(hrdata[0]), .HREADY(hready[0]), .HRESP(hresp[0])
  );

  ahb_sram_slave #(.WAIT_STATES(0)) u_dut1 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel[1]), .HADDR(haddr[1]), .HWRITE(hwrite[1]),
    .HWDATA(hwdata[1]), .HTRANS(htrans[1]), .HSIZE(hsize[1]), .HPROT(hprot[1]),
    .HBURST(hburst[1]), .HRDATA(hrdata[1]), .HREADY(hready[1]), .HRESP(hresp[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 1 : 0;
  endfunction

  function automatic bit exp_err(input logic [31:0] addr, input logic [2:0] size, input logic [3:0] prot);
    int unsigned word;
    bit e;
    word = addr / 4;
    e = 1'b0;
    if (word >= 1024) e = 1'b1;
    if (size > 3'd2) e = 1'b1;
    else if ((addr % (32'd1 << size)) != 0) e = 1'b1;
    if (PROT_EN && !prot[1] && word >= 768) e = 1'b1;
    return e;
  endfunction

  task automatic model_write(input int d, input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd);
    int lo;
    lo = addr % 4;
    for (int b = lo; b < lo + (1 << size); b++) mdl[d][addr/4][8*b +: 8] = wd[8*b +: 8];
    if (size == 3'd2) mval[d][addr/4] = 1'b1;
  endtask

  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wd, input logic [3:0] prot, input string tag);
    bit e, done;
    int lows, cyc;
    e = exp_err(addr, size, prot);
    @(negedge clk);
    haddr[d] = addr; hwrite[d] = wr; hsize[d] = size; hprot[d] = prot;
    hburst[d] = 3'($urandom); htrans[d] = 2'($urandom_range(2, 3)); hsel[d] = 1'b1;
    @(posedge clk); #1;
    htrans[d] = 2'($urandom_range(0, 1)); hsel[d] = 1'($urandom_range(0, 1));
    haddr[d] = $urandom; hwdata[d] = wr ? wd : $urandom;
    lows = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 16) begin
      @(negedge clk);
      cyc++;
      if (hready[d]) begin
        done = 1'b1;
      end else begin
        lows++;
        chk({tag, " resp-stall"}, 64'(hresp[d]), 64'(e));
        chk({tag, " rdata-stall"}, 64'(hrdata[d]), 64'd0);
      end
    end
    if (!done) begin
      chk({tag, " timeout"}, 64'(hready[d]), 64'd1);
    end else begin
      chk({tag, " stall-cycles"}, 64'(lows), e ? 64'd1 : 64'(ws_of(d)));
      chk({tag, " resp"}, 64'(hresp[d]), 64'(e));
      if (e || wr) chk({tag, " rdata-zero"}, 64'(hrdata[d]), 64'd0);
      else if (mval[d][addr/4]) chk({tag, " rdata"}, 64'(hrdata[d]), 64'(mdl[d][addr/4]));
      if (!e && wr) model_write(d, addr, size, wd);
    end
  endtask

  // Back-to-back WORD write then read on the zero-wait instance.
  task automatic pipe(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra, input string tag);
    @(negedge clk);
    chk({tag, " ready-addr"}, 64'(hready[1]), 64'd1);
    haddr[1] = wa; hwrite[1] = 1'b1; hsize[1] = 3'd2; hprot[1] = 4'b0011;
    htrans[1] = 2'b10; hsel[1] = 1'b1;
    @(negedge clk);
    chk({tag, " ready-wdata"}, 64'(hready[1]), 64'd1);
    chk({tag, " resp-wdata"}, 64'(hresp[1]), 64'd0);
    haddr[1] = ra; hwrite[1] = 1'b0; htrans[1] = 2'($urandom_range(2, 3)); hwdata[1] = wd;
    model_write(1, wa, 3'd2, wd);
    @(posedge clk); #1;
    htrans[1] = 2'b00; hsel[1] = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk({tag, " ready-rdata"}, 64'(hready[1]), 64'd1);
    chk({tag, " resp-rdata"}, 64'(hresp[1]), 64'd0);
    chk({tag, " rdata"}, 64'(hrdata[1]), 64'(mdl[1][ra/4]));
  endtask

  initial begin
    logic [31:0] v, a;
    int unsigned w;
    logic [2:0] sz;
    hreset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      hsel[d] = 1'b0; haddr[d] = '0; hwrite[d] = 1'b0; hwdata[d] = '0;
      htrans[d] = 2'b00; hsize[d] = 3'd2; hprot[d] = 4'b0011; hburst[d] = 3'd0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset hready", 64'(hready[d]), 64'd1);
      chk("reset hresp", 64'(hresp[d]), 64'd0);
      chk("reset hrdata", 64'(hrdata[d]), 64'd0);
    end
    hreset = 1'b0;

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 80; i++) xfer(d, 1'b1, 32'(i * 4), 3'd2, $urandom, 4'b0011, "init");
      for (int i = 760; i < 776; i++) xfer(d, 1'b1, 32'(i * 4), 3'd2, $urandom, 4'b0011, "init");
    end

    xfer(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 4'b0011, "word-wr");
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 4'b0011, "word-rd");
    xfer(0, 1'b1, 32'h13, 3'd0, 32'hAA000000, 4'b0011, "byte-wr");
    xfer(0, 1'b0, 32'h10, 3'd2, 32'h0, 4'b0011, "byte-rd");
    xfer(0, 1'b0, 32'h1000, 3'd2, 32'h0, 4'b0011, "oor-rd");
    xfer(0, 1'b1, 32'h21, 3'd1, 32'hFFFFFFFF, 4'b0011, "misalign-wr");
    xfer(0, 1'b0, 32'h20, 3'd2, 32'h0, 4'b0011, "misalign-check");
    pipe(32'h40, 32'h12345678, 32'h40, "pipe-fixed");
    xfer(0, 1'b1, 32'hC00, 3'd2, 32'h0BADF00D, 4'b0001, "prot-user-wr");
    xfer(0, 1'b0, 32'hC00, 3'd2, 32'h0, 4'b0011, "prot-check");
    xfer(0, 1'b1, 32'hC00, 3'd2, 32'h600DCAFE, 4'b0011, "prot-priv-wr");
    xfer(0, 1'b0, 32'hC00, 3'd2, 32'h0, 4'b0011, "prot-priv-rd");

    v = $urandom;
    xfer(0, 1'b1, 32'h100, 3'd2, v, 4'b0011, "pre-reset-wr");
    @(negedge clk);
    haddr[0] = 32'h100; hwrite[0] = 1'b0; hsize[0] = 3'd2; htrans[0] = 2'b10; hsel[0] = 1'b1;
    @(posedge clk); #1;
    htrans[0] = 2'b00;
    @(negedge clk);
    chk("rst-in-wait hready", 64'(hready[0]), 64'd0);
    hreset = 1'b1;
    #1;
    chk("rst-async hready", 64'(hready[0]), 64'd1);
    chk("rst-async hresp", 64'(hresp[0]), 64'd0);
    chk("rst-async hrdata", 64'(hrdata[0]), 64'd0);
    @(negedge clk);
    hreset = 1'b0;
    xfer(0, 1'b0, 32'h100, 3'd2, 32'h0, 4'b0011, "post-reset-rd");

    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 9))
        6, 7:    w = $urandom_range(760, 775);
        8:       w = $urandom_range(1024, 1030);
        9:       w = $urandom_range(64, 79);
        default: w = $urandom_range(0, 15);
      endcase
      sz = 3'($urandom_range(0, 3));
      a  = 32'(w * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1 && sz <= 3'd2) a = a & ~((32'd1 << sz) - 32'd1);
      xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, sz, $urandom, 4'($urandom), "rand");
    end

    for (int i = 0; i < 40; i++) begin
      pipe(32'($urandom_range(0, 7) * 4), $urandom, 32'($urandom_range(0, 7) * 4), "pipe-rand");
    end

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
